// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants for the register-file writeback scheduler and its arbiter.
// The top-level parameters take their default values from here.
package regfile_wb_scheduler_pkg;
  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_XLEN       = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_NUM_REGS   = 1 << DEF_REG_ADDR_W;
  localparam int REG_ZERO       = 0;
endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant; the pointer remembers the last winner.
module regfile_wb_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Search starts one past the last winner and wraps, so the last winner is tried last.
  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PTR_W'(NUM_REQ - 1);
    end else if (found) begin
      ptr <= grant_idx;
    end
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Owns the register-file write port: arbitrates writeback requesters, registers the
// write, and tracks outstanding destinations so issue stalls on RAW/WAW hazards.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int XLEN       = DEF_XLEN,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  input  logic [REG_ADDR_W-1:0]         issue_rs1,
  input  logic [REG_ADDR_W-1:0]         issue_rs2,
  output logic                          issue_stall,
  output logic                          wr_enable,
  output logic [REG_ADDR_W-1:0]         wr_address,
  output logic [XLEN-1:0]               wr_data,
  output logic [(1<<REG_ADDR_W)-1:0]    pending
);
  localparam int NUM_REGS = 1 << REG_ADDR_W;

  logic [NUM_REQ-1:0]    grant;
  logic [REG_ADDR_W-1:0] g_addr;
  logic [XLEN-1:0]       g_data;
  logic [NUM_REGS-1:0]   pending_q;
  logic [NUM_REGS-1:0]   pending_nxt;
  logic                  issue_accept;

  // Requester i transfers on an edge where req_valid[i] & req_ready[i]; ready is derived
  // from valid (never offered to an idle requester), so valid must hold until ready.
  regfile_wb_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;

  always_comb begin
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        g_addr = g_addr | req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        g_data = g_data | req_data[i*XLEN +: XLEN];
      end
    end
  end

  // A granted write to register 0 is consumed but produces no write pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_enable  <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
    end else if (|grant) begin
      wr_enable  <= (g_addr != REG_ADDR_W'(REG_ZERO));
      wr_address <= g_addr;
      wr_data    <= g_data;
    end else begin
      wr_enable  <= 1'b0;
    end
  end

  assign issue_stall  = issue_valid &
                        (pending_q[issue_rs1] | pending_q[issue_rs2] | pending_q[issue_rd]);
  assign issue_accept = issue_valid & ~issue_stall;

  // Clear on the commit edge, then set: a new producer of the same register wins.
  always_comb begin
    pending_nxt = pending_q;
    if (wr_enable) begin
      pending_nxt[wr_address] = 1'b0;
    end
    if (issue_accept && (issue_rd != REG_ADDR_W'(REG_ZERO))) begin
      pending_nxt[issue_rd] = 1'b1;
    end
    pending_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_nxt;
    end
  end

  assign pending = pending_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed vector table, hand-written corner sequences
// and random traffic against a behavioural model; a small array stands in for register_memory.
module tb_regfile_wb_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_stall;
  logic        wr_enable;
  logic [4:0]  wr_address;
  logic [31:0] wr_data;
  logic [31:0] pending;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  regfile_wb_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_stall (issue_stall),
    .wr_enable   (wr_enable),
    .wr_address  (wr_address),
    .wr_data     (wr_data),
    .pending     (pending)
  );

  // register_memory stand-in: commits on the edge where wr_enable is high
  logic        mem_clr;
  logic [31:0] regmem [32];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int r = 0; r < 32; r++) regmem[r] <= 32'h0;
    end else if (wr_enable) begin
      regmem[wr_address] <= wr_data;
    end
  end

  // behavioural reference model
  int         m_last;
  bit         m_wen;
  bit [4:0]   m_waddr;
  bit [31:0]  m_wdata;
  bit [31:0]  m_pend;

  task automatic model_reset();
    m_last = 1; m_wen = 0; m_waddr = 0; m_wdata = 0; m_pend = 0;
  endtask

  function automatic logic [1:0] m_ready();
    logic [1:0] g = 2'b00;
    for (int i = 1; i <= 2; i++) begin
      int k = (m_last + i) % 2;
      if (g == 2'b00 && req_valid[k]) g[k] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic m_stall();
    return issue_valid && (m_pend[issue_rs1] || m_pend[issue_rs2] || m_pend[issue_rd]);
  endfunction

  task automatic model_edge();
    logic [1:0] g = m_ready();
    bit [31:0]  np = m_pend;
    if (m_wen) np[m_waddr] = 1'b0;
    if (issue_valid && !m_stall() && issue_rd != 0) np[issue_rd] = 1'b1;
    m_pend = np;
    if (g != 2'b00) begin
      int k = g[1] ? 1 : 0;
      m_last  = k;
      m_waddr = req_addr[k*5 +: 5];
      m_wdata = req_data[k*32 +: 32];
      m_wen   = (m_waddr != 0);
    end else begin
      m_wen = 1'b0;
    end
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("req_ready",   64'(req_ready),   64'(m_ready()));
    chk("issue_stall", 64'(issue_stall), 64'(m_stall()));
    chk("wr_enable",   64'(wr_enable),   64'(m_wen));
    chk("wr_address",  64'(wr_address),  64'(m_waddr));
    chk("wr_data",     64'(wr_data),     64'(m_wdata));
    chk("pending",     64'(pending),     64'(m_pend));
  endtask

  // one cycle: compare mid-cycle, advance model at the edge, re-drive just after it
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // driver
  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic iv,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    req_valid = v; req_addr = {a1, a0}; req_data = {d1, d0};
    issue_valid = iv; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        iv;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  exp_ready;
    logic        exp_stall;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{2'b11, 5'd5, 5'd6, 32'hABCDEFAB, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0};
    tbl[1]  = '{2'b11, 5'd5, 5'd6, 32'hABCDEFAB, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b0};
    tbl[2]  = '{2'b11, 5'd5, 5'd6, 32'hABCDEFAB, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0};
    tbl[3]  = '{2'b11, 5'd5, 5'd6, 32'hABCDEFAB, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b0};
    tbl[4]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd10, 5'd0, 5'd0, 2'b00, 1'b0};
    tbl[5]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd0, 5'd10, 5'd0, 2'b00, 1'b1};
    tbl[6]  = '{2'b01, 5'd10, 5'd0, 32'hDEADBEEF, 32'h0,       1'b1, 5'd0, 5'd10, 5'd0, 2'b01, 1'b1};
    tbl[7]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd0, 5'd10, 5'd0, 2'b00, 1'b1};
    tbl[8]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd0, 5'd10, 5'd0, 2'b00, 1'b0};
    tbl[9]  = '{2'b01, 5'd0, 5'd0, 32'hEEEEEEEE, 32'h0,        1'b1, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0};
    tbl[10] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0};
    tbl[11] = '{2'b01, 5'd7, 5'd0, 32'h00000077, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0};
    tbl[12] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0};
    tbl[13] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd0, 5'd0, 5'd7, 2'b00, 1'b1};
    tbl[14] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0};

    // reset state
    rst_n = 1'b0; mem_clr = 1'b1;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    model_reset();
    #2;
    chk("rst_wr_enable", 64'(wr_enable), 64'd0);
    chk("rst_pending",   64'(pending),   64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    rst_n   = 1'b1;

    // directed vector table
    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].valid, tbl[k].a0, tbl[k].a1, tbl[k].d0, tbl[k].d1,
            tbl[k].iv, tbl[k].rd, tbl[k].rs1, tbl[k].rs2);
      @(negedge clk);
      check_all();
      chk($sformatf("tbl%0d_ready", k), 64'(req_ready),   64'(tbl[k].exp_ready));
      chk($sformatf("tbl%0d_stall", k), 64'(issue_stall), 64'(tbl[k].exp_stall));
      if (k == 10) chk("reg0_no_wen", 64'(wr_enable), 64'd0);
      if (k == 12) chk("reg7_commit_wen", 64'(wr_enable), 64'd1);
      @(posedge clk);
      model_edge();
      #1;
    end
    chk("reg5_data",    64'(regmem[5]),  64'hABCDEFAB);
    chk("reg6_data",    64'(regmem[6]),  64'h12345678);
    chk("reg10_data",   64'(regmem[10]), 64'hDEADBEEF);
    chk("reg0_data",    64'(regmem[0]),  64'h0);
    chk("pend7_set_wins", 64'(pending[7]), 64'd1);

    // reset in the middle of a write: grant to requester 1 at reg 20 plus an issue to rd=20
    drive(2'b10, 5'd0, 5'd20, 32'h0, 32'h55555555, 1'b1, 5'd20, 5'd0, 5'd0);
    step();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("mid_pre_wen",  64'(wr_enable),   64'd1);
    chk("mid_pre_pend", 64'(pending[20]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_wen",   64'(wr_enable), 64'd0);
    chk("mid_pend",  64'(pending),   64'd0);
    chk("mid_waddr", 64'(wr_address), 64'd0);
    @(posedge clk);
    #1;
    chk("mid_reg20_kept", 64'(regmem[20]), 64'h0);
    rst_n = 1'b1;
    model_reset();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
